// File: rtl/cpu_irq_pkg.sv
// Shared types and constants for the cpu_irq_ctrl interrupt controller.
package cpu_irq_pkg;

  localparam int ID_W = 5;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam int          VEC_STRIDE_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  function automatic logic [31:0] vec_addr(input logic [31:0] base, input int stride,
                                           input logic [ID_W-1:0] id);
    return base + 32'(id) * 32'(stride);
  endfunction

endpackage

// File: rtl/cpu_irq_ctrl_if.sv
// Peripheral/CPU-side signal bundle of the interrupt controller.
interface cpu_irq_ctrl_if
  import cpu_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) ();
  logic [NUM_IRQ-1:0] irq_src;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               interrupt_grant;
  logic               eoi;
  logic               interrupt;
  logic [ID_W-1:0]    irq_id;
  logic [31:0]        irq_vector;
  logic               in_service;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;

  modport master (
    output irq_src, mask_we, mask_wdata, interrupt_grant, eoi,
    input  interrupt, irq_id, irq_vector, in_service, pending, mask
  );
  modport slave (
    input  irq_src, mask_we, mask_wdata, interrupt_grant, eoi,
    output interrupt, irq_id, irq_vector, in_service, pending, mask
  );
endinterface

// File: rtl/cpu_irq_arb.sv
// Combinational winner select; CPU_IRQ_RR_EN selects round-robin, else lowest index wins.
module cpu_irq_arb
  import cpu_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] elig,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    id
);
`ifdef CPU_IRQ_RR_EN
  // Rotate so bit 0 is the pointer position, then map the found offset back.
  logic [NUM_IRQ-1:0] rot;
  int                 sum;
  assign rot = NUM_IRQ'({elig, elig} >> ptr);

  always_comb begin
    valid = 1'b0;
    id    = '0;
    sum   = 0;
    for (int i = NUM_IRQ-1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        sum   = int'(ptr) + i;
        if (sum >= NUM_IRQ) sum = sum - NUM_IRQ;
        id    = ID_W'(sum);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--) begin
      if (elig[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end
`endif
endmodule

// File: rtl/cpu_irq_ctrl.sv
// Edge-triggered, maskable interrupt controller driving cpu_pc's interrupt line.
// Arbitration is fixed priority unless CPU_IRQ_RR_EN is defined (round-robin).
module cpu_irq_ctrl
  import cpu_irq_pkg::*;
#(
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
  input logic           clk,
  input logic           reset,
  cpu_irq_ctrl_if.slave bus
);

  irq_state_e         state, state_nxt;
  logic [NUM_IRQ-1:0] src_q, pending, pending_nxt, mask, evt, elig, id_oh;
  logic [ID_W-1:0]    irq_id, irq_id_nxt, ptr, ptr_nxt, arb_id;
  logic               arb_vld, grant_take, cur_live, interrupt_r, in_service_r;

  assign evt      = bus.irq_src & ~src_q;
  assign elig     = pending & ~mask;
  assign id_oh    = NUM_IRQ'(1) << irq_id;
  assign cur_live = |(elig & id_oh);

  cpu_irq_arb #(.NUM_IRQ(NUM_IRQ)) u_arb (
    .elig  (elig),
    .ptr   (ptr),
    .valid (arb_vld),
    .id    (arb_id)
  );

  always_comb begin
    state_nxt  = state;
    irq_id_nxt = irq_id;
    ptr_nxt    = ptr;
    grant_take = 1'b0;
    case (state)
      ST_IDLE: if (arb_vld) begin
        state_nxt  = ST_REQ;
        irq_id_nxt = arb_id;
      end
      ST_REQ: begin
        // Grant beats a simultaneous mask-out of the requested source.
        if (bus.interrupt_grant) begin
          grant_take = 1'b1;
          state_nxt  = ST_SERVICE;
          ptr_nxt    = (irq_id == ID_W'(NUM_IRQ-1)) ? '0 : irq_id + 1'b1;
        end else if (!cur_live) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: if (bus.eoi) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // A new edge on the granted source survives its own grant clear.
    pending_nxt = (pending & ~(grant_take ? id_oh : '0)) | evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      src_q        <= '0;
      pending      <= '0;
      mask         <= '1;
      irq_id       <= '0;
      ptr          <= '0;
      interrupt_r  <= 1'b0;
      in_service_r <= 1'b0;
    end else begin
      state        <= state_nxt;
      src_q        <= bus.irq_src;
      pending      <= pending_nxt;
      if (bus.mask_we) mask <= bus.mask_wdata;
      irq_id       <= irq_id_nxt;
      ptr          <= ptr_nxt;
      interrupt_r  <= (state_nxt == ST_REQ);
      in_service_r <= (state_nxt == ST_SERVICE);
    end
  end

  assign bus.interrupt  = interrupt_r;
  assign bus.in_service = in_service_r;
  assign bus.irq_id     = irq_id;
  assign bus.irq_vector = vec_addr(VEC_BASE, VEC_STRIDE, irq_id);
  assign bus.pending    = pending;
  assign bus.mask       = mask;

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Directed, table-driven bench for cpu_irq_ctrl plus hand sequences for handshake corners.
module tb_cpu_irq_ctrl;
  import cpu_irq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cpu_irq_ctrl_if #(.NUM_IRQ(8)) bus ();

  cpu_irq_ctrl #(.NUM_IRQ(8), .VEC_BASE(32'h0000_0100), .VEC_STRIDE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] src;
    logic       mwe;
    logic [7:0] mw;
    logic       gnt;
    logic       eoi;
    logic       ei;
    logic       es;
    logic [4:0] eid;
    logic [7:0] ep;
    logic [7:0] em;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] src, input logic mwe, input logic [7:0] mw,
                       input logic gnt, input logic eoi);
    bus.irq_src         = src;
    bus.mask_we         = mwe;
    bus.mask_wdata      = mw;
    bus.interrupt_grant = gnt;
    bus.eoi             = eoi;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [7:0] src, input logic gnt, input logic eoi);
    drive(src, 1'b0, 8'h00, gnt, eoi);
  endtask

  task automatic wait_int(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.interrupt) begin
        ok = 1'b1;
        break;
      end
      cyc(8'h00, 1'b0, 1'b0);
    end
    if (!ok) chk("interrupt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit         ok;
    logic [4:0] exp_rr;
    logic [4:0] got;

    //         src    mwe  mw     gnt  eoi  int  svc  id    pend   mask
    tbl.push_back('{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00});
    tbl.push_back('{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h08, 8'h00});
    tbl.push_back('{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 8'h08, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 8'h08, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 8'h00, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 8'h00, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 8'h00, 8'h00});
    tbl.push_back('{8'h28, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 8'h28, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 8'h28, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 8'h20, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 8'h20, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 8'h20, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 8'h00, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 8'h00, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 8'h00, 8'h00});
    tbl.push_back('{8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 8'h04, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 8'h04, 8'h00});
    tbl.push_back('{8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 8'h04, 8'h04});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 8'h04, 8'h04});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 8'h04, 8'h04});
    tbl.push_back('{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 8'h04, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 8'h04, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 8'h00, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 8'h00, 8'h00});
    tbl.push_back('{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 8'h00, 8'h00});

    bus.irq_src = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.interrupt_grant = 1'b0; bus.eoi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_interrupt", 32'(bus.interrupt), 32'd0);
    chk("rst_in_service", 32'(bus.in_service), 32'd0);
    chk("rst_irq_id", 32'(bus.irq_id), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'h00);
    chk("rst_mask", 32'(bus.mask), 32'hFF);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].src, tbl[i].mwe, tbl[i].mw, tbl[i].gnt, tbl[i].eoi);
      chk($sformatf("row%0d_interrupt", i), 32'(bus.interrupt), 32'(tbl[i].ei));
      chk($sformatf("row%0d_in_service", i), 32'(bus.in_service), 32'(tbl[i].es));
      chk($sformatf("row%0d_irq_id", i), 32'(bus.irq_id), 32'(tbl[i].eid));
      chk($sformatf("row%0d_vector", i), bus.irq_vector, 32'h100 + 32'(tbl[i].eid) * 32'd4);
      chk($sformatf("row%0d_pending", i), 32'(bus.pending), 32'(tbl[i].ep));
      chk($sformatf("row%0d_mask", i), 32'(bus.mask), 32'(tbl[i].em));
    end

    // Grant coincident with a new edge on the granted source.
    cyc(8'h02, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    chk("gs_req_id", 32'(bus.irq_id), 32'd1);
    chk("gs_req_int", 32'(bus.interrupt), 32'd1);
    cyc(8'h02, 1'b1, 1'b0);
    chk("gs_in_service", 32'(bus.in_service), 32'd1);
    chk("gs_pending_kept", 32'(bus.pending), 32'h02);
    chk("gs_int_low", 32'(bus.interrupt), 32'd0);
    cyc(8'h00, 1'b0, 1'b1);
    chk("gs_eoi_idle", 32'(bus.interrupt), 32'd0);
    cyc(8'h00, 1'b0, 1'b0);
    chk("gs_rereq_int", 32'(bus.interrupt), 32'd1);
    chk("gs_rereq_id", 32'(bus.irq_id), 32'd1);
    cyc(8'h00, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b1);

    // Sources 0 and 1 re-pulsed during every handler.
    cyc(8'h03, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
`ifdef CPU_IRQ_RR_EN
      exp_rr = 5'(n % 2);
`else
      exp_rr = 5'd0;
`endif
      wait_int(ok);
      got = bus.irq_id;
      chk($sformatf("arb_grant%0d_id", n), 32'(got), 32'(exp_rr));
      cyc(8'h00, 1'b1, 1'b0);
      cyc(8'h03, 1'b0, 1'b0);
      cyc(8'h00, 1'b0, 1'b0);
      cyc(8'h00, 1'b0, 1'b1);
    end

    // Reset asserted while a handler is running.
    wait_int(ok);
    cyc(8'h00, 1'b1, 1'b0);
    chk("rs_pre_in_service", 32'(bus.in_service), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_interrupt", 32'(bus.interrupt), 32'd0);
    chk("rs_in_service", 32'(bus.in_service), 32'd0);
    chk("rs_irq_id", 32'(bus.irq_id), 32'd0);
    chk("rs_vector", bus.irq_vector, 32'h0000_0100);
    chk("rs_pending", 32'(bus.pending), 32'h00);
    chk("rs_mask", 32'(bus.mask), 32'hFF);
    cyc(8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(8'h00, 1'b0, 1'b1);
    chk("rs_eoi_in_service", 32'(bus.in_service), 32'd0);
    chk("rs_eoi_interrupt", 32'(bus.interrupt), 32'd0);
    cyc(8'h00, 1'b0, 1'b0);
    chk("rs_idle_interrupt", 32'(bus.interrupt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_irq_ctrl.md
# cpu_irq_ctrl

Interrupt controller sitting in front of `cpu_pc`: collects up to `NUM_IRQ` edge-triggered peripheral interrupt sources, masks and prioritises them, and drives the single `interrupt` request line of `cpu_pc`. It completes the `interrupt`/`interrupt_grant` handshake, presents the winning source ID and its vector address, and holds off further requests until the handler signals end-of-interrupt.

## Interface
- `NUM_IRQ`, 8, number of interrupt sources (2..32)
- `VEC_BASE`, 32'h0000_0100, vector address of source 0
- `VEC_STRIDE`, 4, byte spacing between consecutive vectors

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `irq_src`  in  NUM_IRQ  raw source lines, rising edge = event
- `mask_we`  in  1  write strobe for mask register
- `mask_wdata`  in  NUM_IRQ  new mask value (1 = masked)
- `interrupt_grant`  in  1  one-cycle pulse from `cpu_pc`: request taken
- `eoi`  in  1  one-cycle end-of-interrupt pulse from handler
- `interrupt`  out  1  request to `cpu_pc`, registered
- `irq_id`  out  5  ID of requested/in-service source
- `irq_vector`  out  32  VEC_BASE + irq_id*VEC_STRIDE
- `in_service`  out  1  high while a handler is running
- `pending`  out  NUM_IRQ  pending bits (debug/readback)
- `mask`  out  NUM_IRQ  current mask register

## Operation
- Edge detect: `src_q` registers `irq_src`; event = `irq_src & ~src_q`; event sets `pending[i]` on that edge.
- Mask write: `mask_we` updates `mask` at the clock edge; masking does not clear pending bits.
- Eligible = `pending & ~mask`.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if eligible != 0 -> REQ; latch winner into `irq_id`; `interrupt`=1.
  - REQ: `interrupt_grant`=1 -> clear `pending[irq_id]`, `interrupt`=0, `in_service`=1, -> SERVICE. Else if `pending[irq_id] & ~mask[irq_id]` becomes 0 (masked) -> withdraw, `interrupt`=0, -> IDLE.
  - SERVICE: `eoi`=1 -> `in_service`=0, -> IDLE. No nesting.
- Grant and masking on the same edge in REQ: grant wins.
- New event on `irq_id` in the same cycle as grant clear: set wins; pending stays 1.
- `eoi` outside SERVICE and `interrupt_grant` outside REQ: ignored.
- `irq_id` is stable from REQ entry until return to IDLE; `irq_vector` is a combinational function of `irq_id` (32-bit, wraps mod 2^32).
- Reset, including mid-handshake: state IDLE; `interrupt`=0, `in_service`=0, `irq_id`=0, `pending`=0, `src_q`=0, `mask`=all ones. The arbiter pointer resets to 0.

## Timing
- Source rising edge first sampled at edge k -> `pending` set after k -> `interrupt`=1 after k+1 (2-cycle latency).
- Grant at edge g -> `interrupt`=0 and `in_service`=1 after g.
- `eoi` at edge e -> IDLE after e; a still-eligible source re-raises `interrupt` after e+1.
- Sources must hold high at least one clock; pulses shorter than one clock may be lost.

## Configuration
- `CPU_IRQ_RR_EN` defined: round-robin arbitration. Search starts at the index after the last granted ID, wrapping at NUM_IRQ-1 -> 0. The pointer updates on grant only.
- Not defined: fixed priority, lowest index wins.

## Structure
- Package `cpu_irq_pkg`: FSM state encoding (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), ID width constant (5), default vector constants.
- One sub-module, `cpu_irq_arb`: combinational winner selection from eligible vector and pointer, fixed or round-robin per macro, outputs `valid` and `id`.

## Test plan
- Reset, mask=8'h00, pulse `irq_src[3]` -> `interrupt`=1 two cycles later, `irq_id`=3, `irq_vector`=32'h0000_010C.
- Pending 3 and 5 simultaneously, fixed priority -> ID 3 granted. After `eoi`, ID 5 requested with `irq_vector`=32'h0000_0114.
- `CPU_IRQ_RR_EN`: sources 0 and 1 re-pulsed every handler -> grants alternate 0,1,0,1.
- In REQ for ID 2, write mask=8'h04 with no grant -> `interrupt` drops next cycle, state IDLE, `pending[2]` still 1. Unmask -> re-request.
- Grant pulse coincident with new edge on the same source -> `in_service`=1 and `pending` bit remains 1. Re-request follows `eoi`.
- Assert `reset` while in SERVICE -> all outputs at reset values immediately; `mask`=8'hFF; `eoi` afterwards has no effect.
